// File: rtl/load_store_memory_if.sv
// Request/response bus between the load/store stage and the data memory.
// A request is taken on a rising edge where req_valid && req_ready; the requester holds all req_* fields stable until then, and the response is a single-cycle resp_valid pulse.
interface load_store_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/load_store_memory.sv
// Byte-addressed little-endian data memory with byte/half/word loads and stores,
// sign/zero extension on loads and a configurable load latency.
module load_store_memory #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    load_store_memory_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  lat_cnt;
    logic [31:0] hold_data;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;

    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          req_err;
    logic          addr_oob;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   load_val;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_error = resp_error_q;
    assign dbg_state      = state;

    assign accept   = bus.req_valid && bus.req_ready;
    assign widx     = bus.req_addr[AW+1:2];
    assign lane     = bus.req_addr[1:0];
    assign addr_oob = |bus.req_addr[31:AW+2];

    always_comb begin
        req_err = addr_oob;
        case (bus.req_size)
            2'b01:   if (lane[0]) req_err = 1'b1;
            2'b10:   if (lane != 2'b00) req_err = 1'b1;
            2'b11:   req_err = 1'b1;
            default: ;
        endcase
    end

    // Lane data is shifted down to bit 0 first, so extension always reads bit 7 or 15.
    always_comb begin
        rd_word  = mem[widx];
        rd_shift = rd_word >> {lane, 3'b000};
        case (bus.req_size)
            2'b00:   load_val = {{24{~bus.req_unsigned & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   load_val = {{16{~bus.req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        case (bus.req_size)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = bus.req_wdata;
            end
        endcase
    end

    // Contents survive reset; a store coinciding with reset is suppressed.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.req_write && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[widx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lat_cnt      <= 3'd0;
            hold_data    <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err || bus.req_write) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= req_err;
                        end else if (READ_LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= load_val;
                        end else begin
                            state     <= WAIT;
                            lat_cnt   <= LAT_INIT;
                            hold_data <= load_val;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd1) begin
                        state        <= RESP;
                        lat_cnt      <= 3'd0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= hold_data;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
